// File: rtl/prog_fetch_seq_if.sv
// prog_fetch_seq_if
//   Bus bundle between the fetch sequencer, the program bit memory and the
//   IL execute core.
//   A           : program memory address (sequencer -> memory)
//   DQ          : program memory read data, combinational on A
//   INSTR       : instruction presented to the execute core
//   INSTR_VALID : INSTR is valid
//   INSTR_READY : execute core accepts INSTR
//   master = sequencer side, slave = memory/core side.
interface prog_fetch_seq_if #(
    parameter int DW = 18,
    parameter int AW = 12
);
    logic [AW-1:0] A;
    logic [DW-1:0] DQ;
    logic [DW-1:0] INSTR;
    logic          INSTR_VALID;
    logic          INSTR_READY;

    modport master (
        output A, INSTR, INSTR_VALID,
        input  DQ, INSTR_READY
    );

    modport slave (
        input  A, INSTR, INSTR_VALID,
        output DQ, INSTR_READY
    );
endinterface

// File: rtl/prog_fetch_seq.sv
// prog_fetch_seq
//   Instruction fetch / scan sequencer for the PLC program memory. Walks the
//   program from address 0, swallows JMP and END opcodes locally, issues every
//   other word to the execute core over valid/ready, and counts scans. A step
//   counter trips a sticky watchdog fault if a scan runs away.
// Ports:
//   CLK, RST   : clock (rising edge), synchronous active-high reset
//   RUN        : level, 1 = run scans continuously
//   bus        : master side of prog_fetch_seq_if (A/DQ memory, INSTR handshake)
//   SCAN_DONE  : one-cycle pulse per END reached
//   SCAN_CNT   : completed scan count, wraps
//   WD_ERR     : sticky watchdog fault, cleared only by RST
module prog_fetch_seq #(
    parameter int          DW        = 18,
    parameter int          AW        = 12,
    parameter logic [5:0]  OP_END    = 6'h3F,
    parameter logic [5:0]  OP_JMP    = 6'h3E,
    parameter logic [15:0] MAX_STEPS = 16'd8192
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     RUN,
    prog_fetch_seq_if.master         bus,
    output logic                     SCAN_DONE,
    output logic [15:0]              SCAN_CNT,
    output logic                     WD_ERR
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WRAP,
        S_FAULT
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_pc;
    logic [DW-1:0] r_instr;
    logic          r_valid;
    logic          r_done;
    logic [15:0]   r_scan_cnt;
    logic          r_wd_err;
    logic [15:0]   r_steps;

    logic [5:0]    w_op;
    logic [AW-1:0] w_tgt;

    assign w_op  = bus.DQ[DW-1:DW-6];
    assign w_tgt = bus.DQ[AW-1:0];

    assign bus.A           = r_pc;
    assign bus.INSTR       = r_instr;
    assign bus.INSTR_VALID = r_valid;
    assign SCAN_DONE       = r_done;
    assign SCAN_CNT        = r_scan_cnt;
    assign WD_ERR          = r_wd_err;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_pc       <= '0;
            r_instr    <= '0;
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
            r_scan_cnt <= '0;
            r_wd_err   <= 1'b0;
            r_steps    <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    r_pc    <= '0;
                    r_steps <= '0;
                    if (RUN) r_state <= S_FETCH;
                end

                S_FETCH: begin
                    // Every fetch cycle counts toward the watchdog, including
                    // swallowed JMP/END words.
                    r_steps <= r_steps + 16'd1;
                    if (!RUN) begin
                        r_state <= S_IDLE;
                        r_pc    <= '0;
                        r_steps <= '0;
                    end else if (r_steps == MAX_STEPS - 16'd1) begin
                        r_state  <= S_FAULT;
                        r_wd_err <= 1'b1;
                    end else if (w_op == OP_END) begin
                        // Pulse is raised on entry so it is high during WRAP.
                        r_state <= S_WRAP;
                        r_done  <= 1'b1;
                    end else if (w_op == OP_JMP) begin
                        r_pc <= w_tgt;
                    end else begin
                        r_instr <= bus.DQ;
                        r_valid <= 1'b1;
                        r_state <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    // RUN is deliberately ignored: an issued word always
                    // completes its handshake.
                    if (bus.INSTR_READY) begin
                        r_valid <= 1'b0;
                        r_pc    <= r_pc + 1'b1;  // wraps modulo 2^AW
                        r_state <= S_FETCH;
                    end
                end

                S_WRAP: begin
                    r_scan_cnt <= r_scan_cnt + 16'd1;
                    r_pc       <= '0;
                    r_steps    <= '0;
                    r_state    <= RUN ? S_FETCH : S_IDLE;
                end

                S_FAULT: begin
                    r_valid  <= 1'b0;
                    r_wd_err <= 1'b1;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/prog_fetch_seq.md
Name: prog_fetch_seq

Overview:
- Instruction fetch and scan sequencer; sits directly downstream of the 18-bit x 4096-word program bit memory.
- Drives the memory address from an internal program counter and captures the asynchronously read word.
- Presents each logic instruction to the IL execute core over a valid/ready handshake.
- Handles in-line JMP and END opcodes itself, so one PLC scan runs from address 0 to END.
- Provides scan-complete pulses, a scan counter and a watchdog fault for runaway scans.

Parameters:
- DW, 18: instruction width; opcode = [DW-1:DW-6], operand = [AW-1:0].
- AW, 12: program address width.
- OP_END, 6'h3F: end-of-scan opcode.
- OP_JMP, 6'h3E: unconditional jump opcode; operand = target address.
- MAX_STEPS, 16'd8192: maximum fetches per scan before watchdog fault.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous reset, active-high.
- RUN  in  1  level; 1 = execute scans continuously.
- A  out  AW  program memory address; always equals PC.
- DQ  in  DW  program memory read data; combinational, valid in the same cycle as A.
- INSTR  out  DW  instruction presented to the execute core.
- INSTR_VALID  out  1  INSTR is valid.
- INSTR_READY  in  1  execute core accepts INSTR.
- SCAN_DONE  out  1  one-cycle pulse when END is reached.
- SCAN_CNT  out  16  completed scans; wraps 16'hFFFF -> 0.
- WD_ERR  out  1  sticky watchdog fault.

Behaviour:
- Reset (RST=1 at a CLK edge; overrides everything, including mid-handshake):
  - PC=0, state=IDLE, INSTR=0, INSTR_VALID=0, SCAN_DONE=0, SCAN_CNT=0, WD_ERR=0, step counter=0.
- States: IDLE, FETCH, ISSUE, WRAP, FAULT.
- IDLE:
  - PC held at 0, outputs quiet.
  - RUN=1 -> FETCH next cycle.
- FETCH (DQ decoded in the same cycle; step counter +1):
  - RUN=0 -> IDLE, PC<=0. No instruction is issued.
  - Else, step counter == MAX_STEPS-1 -> FAULT, WD_ERR<=1.
  - Else, opcode == OP_END -> WRAP.
  - Else, opcode == OP_JMP -> PC<=DQ[AW-1:0], stay in FETCH. The jump is never issued to the core and costs 1 cycle.
  - Else -> INSTR<=DQ, INSTR_VALID<=1, go to ISSUE.
- ISSUE:
  - INSTR and INSTR_VALID are held stable until INSTR_READY=1.
  - On VALID&READY: INSTR_VALID<=0 and PC<=PC+1. PC wraps modulo 2^AW, so 12'hFFF -> 0 with no fault. Next state is FETCH.
  - RUN is ignored here; a pending instruction always completes its handshake.
  - Minimum throughput: 2 cycles per instruction when READY is held at 1.
- WRAP (1 cycle):
  - SCAN_DONE=1, SCAN_CNT<=SCAN_CNT+1, PC<=0, step counter<=0.
  - Next state: RUN=1 -> FETCH, else IDLE.
- FAULT:
  - PC frozen, INSTR_VALID=0, WD_ERR=1.
  - Only RST exits this state; RUN is ignored.
- Step counter:
  - 16 bits; counts FETCH cycles (issued, JMP and END) since the last WRAP or IDLE.
  - Cleared on entering IDLE.
- SCAN_DONE is registered and high for exactly one cycle per END.
- The block never writes memory; its loader owns WE/DI.

Test Plan:
1. Program {0:18'h00005, 1:18'h01007, 2:18'h3F000}, RUN=1, READY=1.
   - INSTR 18'h00005, then 18'h01007, each VALID for 1 cycle.
   - SCAN_DONE pulses; SCAN_CNT=1; A returns to 0; scans repeat.
2. Same program, READY held 0 for 5 cycles at the first issue.
   - INSTR=18'h00005 and VALID stable all 5 cycles; PC stays 0 until READY=1.
3. Program {0:18'h3E005, 5:18'h02001, 6:18'h3F000}.
   - Only 18'h02001 is issued; A sequence 0,5,5,6,0.
4. Program {0:18'h3E000} (self-jump), MAX_STEPS=16.
   - WD_ERR=1 after 16 FETCH cycles; VALID stays 0; RST clears WD_ERR and PC.
5. RUN dropped while in ISSUE with READY=0.
   - INSTR is held until READY; after acceptance the next FETCH goes to IDLE with A=0.
   - No SCAN_DONE and SCAN_CNT unchanged.
6. Program starting at 12'hFFF with no END; RST asserted mid-handshake.
   - PC wraps 12'hFFF -> 0.
   - RST mid-handshake: next cycle VALID=0, A=0, SCAN_CNT=0.
